pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 32 (XLEN): payload width, sized to $bits of a pipeline tdata struct.
- REQ-002 SHALL have parameter DEPTH, default 2: number of storage entries, legal range 1..16, any integer (not restricted to powers of two).
- REQ-003 SHALL have parameter FALLTHROUGH, default 0: 1 selects zero-latency bypass when empty; 0 selects registered output.
- REQ-004 Port clk, input, 1: sole clock, all state updates on the rising edge.
- REQ-005 Port rst_n, input, 1: reset, synchronous, active-low.
- REQ-006 Port flush, input, 1: discard all held and incoming entries (pipeline redirect/trap).
- REQ-007 Port s_tvalid, input, 1: upstream payload valid.
- REQ-008 Port s_tready, output, 1: buffer can accept upstream payload.
- REQ-009 Port s_tdata, input, DATA_WIDTH: upstream payload.
- REQ-010 Port m_tvalid, output, 1: downstream payload valid.
- REQ-011 Port m_tready, input, 1: downstream accepts payload.
- REQ-012 Port m_tdata, output, DATA_WIDTH: downstream payload (oldest entry).
- REQ-013 Port count, output, $clog2(DEPTH+1): number of stored entries.

Function
- REQ-014 Push SHALL occur when s_tvalid && s_tready; pop SHALL occur when m_tvalid && m_tready.
- REQ-015 Storage SHALL be a circular buffer with read and write pointers, each incrementing on pop/push and wrapping from DEPTH-1 to 0.
- REQ-016 s_tready SHALL be (count < DEPTH) && !flush, with no combinational path from m_tready; when full, a simultaneous pop SHALL NOT enable a push in the same cycle.
- REQ-017 With count>0, m_tvalid SHALL be 1 (unless flush) and m_tdata SHALL equal the entry at the read pointer.
- REQ-018 Payloads SHALL emerge in acceptance order with no loss or duplication.
- REQ-019 FALLTHROUGH=0: a push into an empty buffer SHALL appear on m_tvalid/m_tdata in the next cycle (latency 1); with count=0, m_tvalid SHALL be 0.
- REQ-020 FALLTHROUGH=1 and count=0: m_tvalid SHALL equal s_tvalid && !flush and m_tdata SHALL equal s_tdata; if m_tready is also 1, the payload SHALL pass through without being stored (count stays 0); otherwise it SHALL be stored.
- REQ-021 A simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged and advance both pointers.
- REQ-022 count SHALL update as count + push - pop, and SHALL never exceed DEPTH or underflow.
- REQ-023 m_tdata and m_tvalid SHALL remain stable while m_tvalid && !m_tready && !flush.
- REQ-024 flush SHALL have priority over all other events: in the flush cycle, m_tvalid=0 and s_tready=0; at the following edge, count=0 and both pointers=0; s_tdata offered during flush SHALL be dropped.
- REQ-025 flush while empty SHALL be harmless (state unchanged apart from pointers returning to 0).
- REQ-026 Storage contents SHALL need no reset; only pointers and count SHALL be reset.

Reset
- REQ-027 While rst_n=0 at an edge: count=0, read/write pointers=0, and from the next cycle m_tvalid=0 and s_tready=1.
- REQ-028 Reset asserted mid-operation (non-empty, full, or during flush) SHALL discard all entries identically to REQ-027.
- REQ-029 The first push SHALL be accepted in the first cycle in which rst_n=1.

Verification
- REQ-030 DEPTH=2, FALLTHROUGH=0: push 0xA, 0xB with m_tready=0 -> count=2, s_tready=0; then m_tready=1 -> 0xA, then 0xB out on consecutive cycles, count 2->1->0.
- REQ-031 DEPTH=3: 10 back-to-back pushes with m_tready=1 continuously -> all 10 values emerge in order at 1 beat/cycle after 1-cycle latency; pointers wrap 2->0 without loss.
- REQ-032 FALLTHROUGH=1, empty, s_tvalid=1, s_tdata=0x55, m_tready=1 -> m_tvalid=1 and m_tdata=0x55 in the same cycle, count stays 0.
- REQ-033 DEPTH=4 holding 3 entries; flush=1 with s_tvalid=1 -> s_tready=0 and m_tvalid=0 that cycle; next cycle count=0 and the flushed data never appears.
- REQ-034 Full DEPTH=2 buffer, m_tready=1 and s_tvalid=1 -> pop only, count=1; push accepted the following cycle.
- REQ-035 Randomised valid/ready with periodic flush and rst_n pulses against a scoreboard queue model -> no ordering violation, REQ-023 stability holds, count matches the model every cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: circular-buffer pipeline stage with optional zero-latency bypass and flush
module pipe_stage_buf #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 2,
    parameter bit FALLTHROUGH = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [DATA_WIDTH-1:0]        s_tdata,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  empty, bypass, push, pop, wr_en, rd_en;

    // handshakes, bypass selection and next pointer/count state
    always_comb begin
        empty    = cnt_q == '0;
        bypass   = FALLTHROUGH && empty;
        s_tready = (cnt_q < CW'(DEPTH)) && !flush;
        m_tvalid = !flush && (empty ? (bypass && s_tvalid) : 1'b1);
        m_tdata  = bypass ? s_tdata : mem_q[rd_q];
        push     = s_tvalid && s_tready;
        pop      = m_tvalid && m_tready;
        wr_en    = push && !(bypass && pop);
        rd_en    = pop && !empty;
        wr_d     = wr_en ? (wr_q == PW'(DEPTH-1) ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d     = rd_en ? (rd_q == PW'(DEPTH-1) ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d    = cnt_q + CW'(wr_en) - CW'(rd_en);
    end

    // pointer and occupancy registers; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // payload storage, not reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= s_tdata;
    end

    assign count = cnt_q;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed and scoreboard checks of pipe_stage_buf
module tb_pipe_stage_buf;
    logic clk = 1'b0, rst_n = 1'b0;
    int   errors = 0, checks = 0;

    logic       a_fl, a_sv, a_sr, a_mv, a_mr;
    logic [7:0] a_sd, a_md;
    logic [1:0] a_cnt;
    logic       b_fl, b_sv, b_sr, b_mv, b_mr;
    logic [7:0] b_sd, b_md;
    logic [1:0] b_cnt;
    logic       c_fl, c_sv, c_sr, c_mv, c_mr;
    logic [7:0] c_sd, c_md;
    logic [2:0] c_cnt;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_WIDTH(8), .DEPTH(2), .FALLTHROUGH(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl), .s_tvalid(a_sv), .s_tready(a_sr), .s_tdata(a_sd),
        .m_tvalid(a_mv), .m_tready(a_mr), .m_tdata(a_md), .count(a_cnt));
    pipe_stage_buf #(.DATA_WIDTH(8), .DEPTH(3), .FALLTHROUGH(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl), .s_tvalid(b_sv), .s_tready(b_sr), .s_tdata(b_sd),
        .m_tvalid(b_mv), .m_tready(b_mr), .m_tdata(b_md), .count(b_cnt));
    pipe_stage_buf #(.DATA_WIDTH(8), .DEPTH(4), .FALLTHROUGH(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_fl), .s_tvalid(c_sv), .s_tready(c_sr), .s_tdata(c_sd),
        .m_tvalid(c_mv), .m_tready(c_mr), .m_tdata(c_md), .count(c_cnt));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] prev_md;
        logic       hold, emv, esr;
        int         k;
        {a_fl, a_sv, a_mr, a_sd} = '0;
        {b_fl, b_sv, b_mr, b_sd} = '0;
        {c_fl, c_sv, c_mr, c_sd} = '0;
        tick();
        tick();
        check("rst_cnt_held", a_cnt, 0);
        rst_n = 1'b1;
        #1;
        check("rst_mvalid", a_mv, 0);
        check("rst_sready", a_sr, 1);
        check("rst_cnt", c_cnt, 0);

        // DEPTH=2 fill then drain; first push on first cycle out of reset
        a_sv = 1; a_sd = 8'h0A; a_mr = 0;
        tick();
        check("a_first_cnt", a_cnt, 1);
        check("a_first_mv", a_mv, 1);
        check("a_first_md", a_md, 8'h0A);
        a_sd = 8'h0B;
        tick();
        a_sv = 0;
        #1;
        check("a_full_cnt", a_cnt, 2);
        check("a_full_sr", a_sr, 0);
        check("a_hold_md", a_md, 8'h0A);
        a_mr = 1;
        #1;
        check("a_out0_md", a_md, 8'h0A);
        tick();
        check("a_out1_cnt", a_cnt, 1);
        check("a_out1_md", a_md, 8'h0B);
        tick();
        check("a_empty_cnt", a_cnt, 0);
        check("a_empty_mv", a_mv, 0);
        a_mr = 0;

        // full buffer: simultaneous pop does not free a slot for a same-cycle push
        a_sv = 1; a_sd = 8'h01;
        tick();
        a_sd = 8'h02;
        tick();
        a_sd = 8'h03; a_mr = 1;
        #1;
        check("a_full_pop_sr", a_sr, 0);
        tick();
        check("a_full_pop_cnt", a_cnt, 1);
        check("a_full_pop_md", a_md, 8'h02);
        check("a_full_pop_sr1", a_sr, 1);
        a_mr = 0;
        tick();
        a_sv = 0;
        check("a_late_push_cnt", a_cnt, 2);
        a_mr = 1;
        tick();
        check("a_drain_md", a_md, 8'h03);
        tick();
        check("a_drain_cnt", a_cnt, 0);
        a_mr = 0;

        // DEPTH=3 streaming: 10 pushes, latency 1, one beat per cycle
        k = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            b_sv = cyc < 10; b_sd = 8'h10 + 8'(cyc); b_mr = 1;
            #1;
            if (cyc < 10) check("b_stream_sr", b_sr, 1);
            check("b_stream_mv", b_mv, (cyc >= 1 && cyc <= 10) ? 1 : 0);
            if (b_mv) begin
                check("b_stream_md", b_md, 8'h10 + 8'(k));
                k++;
            end
            tick();
        end
        b_sv = 0; b_mr = 0;
        check("b_stream_total", k, 10);
        check("b_stream_cnt", b_cnt, 0);

        // fallthrough: bypass with ready, store without
        c_sv = 1; c_sd = 8'h55; c_mr = 1;
        #1;
        check("c_ft_mv", c_mv, 1);
        check("c_ft_md", c_md, 8'h55);
        tick();
        check("c_ft_cnt", c_cnt, 0);
        c_sd = 8'h66; c_mr = 0;
        #1;
        check("c_ft_nr_md", c_md, 8'h66);
        tick();
        check("c_store_cnt", c_cnt, 1);
        check("c_store_md", c_md, 8'h66);
        c_sd = 8'h77;
        tick();
        c_sd = 8'h88;
        tick();
        check("c_three_cnt", c_cnt, 3);

        // flush beats a pending push; flushed data never reappears
        c_fl = 1; c_sd = 8'h99;
        #1;
        check("c_flush_sr", c_sr, 0);
        check("c_flush_mv", c_mv, 0);
        tick();
        c_fl = 0; c_sv = 0;
        #1;
        check("c_post_flush_cnt", c_cnt, 0);
        check("c_post_flush_mv", c_mv, 0);
        c_sv = 1; c_sd = 8'hAA;
        tick();
        c_sv = 0;
        #1;
        check("c_after_flush_md", c_md, 8'hAA);
        check("c_after_flush_cnt", c_cnt, 1);

        // reset mid-operation discards entries
        rst_n = 0;
        tick();
        rst_n = 1;
        #1;
        check("c_mid_rst_cnt", c_cnt, 0);
        check("c_mid_rst_mv", c_mv, 0);

        // randomised traffic on DEPTH=3 against a queue model
        q.delete();
        hold = 0; prev_md = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            b_sv = 1'($urandom_range(0, 1));
            b_mr = 1'($urandom_range(0, 2) != 0);
            b_sd = 8'($urandom);
            b_fl = $urandom_range(0, 19) == 0;
            rst_n = $urandom_range(0, 49) != 0;
            #1;
            emv = !b_fl && q.size() > 0;
            esr = !b_fl && q.size() < 3;
            check("r_cnt", b_cnt, q.size());
            check("r_mv", b_mv, emv);
            check("r_sr", b_sr, esr);
            if (emv) check("r_md", b_md, q[0]);
            if (hold && !b_fl) check("r_stable", b_md, prev_md);
            hold = rst_n && emv && !b_mr;
            prev_md = b_md;
            if (!rst_n || b_fl) q.delete();
            else begin
                if (emv && b_mr) void'(q.pop_front());
                if (b_sv && esr) q.push_back(b_sd);
            end
            tick();
        end
        rst_n = 1; b_fl = 0; b_sv = 0; b_mr = 0;
        #1;
        check("r_final_cnt", b_cnt, q.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
